// File: rtl/data_sync_rx_if.sv
// ---------------------------------------------------------------------------
// data_sync_rx_if
// Bundles the bus-side signals of the data_sync_rx CDC receive stage.
//   master : source/consumer side (drives UNSYNC_BUS, BUS_EN, READY, CLR_OVR)
//   slave  : the receive stage itself (drives SYNC_BUS, VALID, ENABLE_PULSE,
//            OVERRUN, DROP_CNT)
// Ports (signals):
//   UNSYNC_BUS   [BUS_WIDTH]  source-domain data word
//   BUS_EN       1            source-domain level enable
//   READY        1            consumer accepts the pending word
//   CLR_OVR      1            clear OVERRUN and DROP_CNT
//   SYNC_BUS     [BUS_WIDTH]  captured word
//   VALID        1            word pending for the consumer
//   ENABLE_PULSE 1            one-cycle strobe per capture
//   OVERRUN      1            sticky dropped-word flag
//   DROP_CNT     [CNT_WIDTH]  saturating dropped-word count
// ---------------------------------------------------------------------------
interface data_sync_rx_if #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] UNSYNC_BUS;
    logic                 BUS_EN;
    logic                 READY;
    logic                 CLR_OVR;
    logic [BUS_WIDTH-1:0] SYNC_BUS;
    logic                 VALID;
    logic                 ENABLE_PULSE;
    logic                 OVERRUN;
    logic [CNT_WIDTH-1:0] DROP_CNT;

    modport master (
        output UNSYNC_BUS, BUS_EN, READY, CLR_OVR,
        input  SYNC_BUS, VALID, ENABLE_PULSE, OVERRUN, DROP_CNT
    );

    modport slave (
        input  UNSYNC_BUS, BUS_EN, READY, CLR_OVR,
        output SYNC_BUS, VALID, ENABLE_PULSE, OVERRUN, DROP_CNT
    );
endinterface

// File: rtl/data_sync_rx.sv
// ---------------------------------------------------------------------------
// data_sync_rx
// Receive-side CDC stage for a multi-bit bus. The level enable is passed
// through a NUM_STAGES flop chain; its rising edge captures the quasi-static
// bus, which is then offered to a local consumer via VALID/READY. Words that
// arrive while the previous one is still unconsumed are dropped, flagged and
// counted.
// Ports:
//   CLK  destination-domain clock
//   RST  asynchronous active-high reset
//   rx   data_sync_rx_if.slave bundle (see interface header)
//
// state   | meaning
// --------+--------------------------------------------
// IDLE    | no word pending, VALID=0
// PENDING | captured word waiting for READY, VALID=1
// ---------------------------------------------------------------------------
module data_sync_rx #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int CNT_WIDTH  = 8
) (
    input logic           CLK,
    input logic           RST,
    data_sync_rx_if.slave rx
);

    generate
        if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
            $error("data_sync_rx: NUM_STAGES must be in 2..4");
        end
    endgenerate

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [NUM_STAGES-1:0] sync_q;
    logic                  en_s;
    logic                  en_d;
    logic                  rise;
    logic                  capture;
    logic                  drop;
    logic [BUS_WIDTH-1:0]  sync_bus;
    logic                  enable_pulse;
    logic                  overrun;
    logic [CNT_WIDTH-1:0]  drop_cnt;

    // Enable synchronizer and edge-detect flop
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            en_d   <= 1'b0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], rx.BUS_EN};
            en_d   <= en_s;
        end
    end

    assign en_s = sync_q[NUM_STAGES-1];
    // Only the rising edge matters; falling edges of en_s are ignored.
    assign rise = en_s & ~en_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    capture   = 1'b1;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (rise) begin
                    // Consume and arrive in the same cycle is a clean hand-over.
                    if (rx.READY) begin
                        capture = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (rx.READY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture register: UNSYNC_BUS is not synchronized, it is only sampled
    // once rise guarantees it has been stable for several cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_bus     <= '0;
            enable_pulse <= 1'b0;
        end else begin
            enable_pulse <= capture;
            if (capture) begin
                sync_bus <= rx.UNSYNC_BUS;
            end
        end
    end

    // Clear has priority over a drop in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (rx.CLR_OVR) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (!(&drop_cnt)) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign rx.SYNC_BUS     = sync_bus;
    assign rx.VALID        = (state == PENDING);
    assign rx.ENABLE_PULSE = enable_pulse;
    assign rx.OVERRUN      = overrun;
    assign rx.DROP_CNT     = drop_cnt;

endmodule

// File: tb/tb_data_sync_rx.sv
// ---------------------------------------------------------------------------
// tb_data_sync_rx
// Self-checking bench for data_sync_rx. A transaction-level reference model
// turns each sampled BUS_EN rising edge into an arrival NUM_STAGES edges later
// and decides capture/drop/consume from the handshake rules; captures are
// queued as expected words and popped by the monitor on ENABLE_PULSE.
// ---------------------------------------------------------------------------
module tb_data_sync_rx;
    localparam int NS   = 2;
    localparam int BW   = 8;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    data_sync_rx_if #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) rx ();

    data_sync_rx #(
        .NUM_STAGES(NS),
        .BUS_WIDTH (BW),
        .CNT_WIDTH (CW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .rx (rx)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [BW-1:0] word;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            arr_q[$];
    int            n_tests        = 0;
    int            n_fail         = 0;
    int            ecyc           = 0;
    int            pulse_cnt      = 0;
    int            last_pulse_cyc = -1;
    int            start_cyc      = 0;
    bit            m_valid        = 1'b0;
    bit            m_ovr          = 1'b0;
    bit            prev_en        = 1'b0;
    int            m_cnt          = 0;
    logic [BW-1:0] m_word         = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecyc);
        end
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    endtask

    // Reference model, evaluated on the inputs sampled at each rising edge.
    task automatic model_edge();
        bit   arrival;
        exp_t e;
        if (RST) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_cnt   = 0;
            m_word  = '0;
            prev_en = 1'b0;
            arr_q.delete();
            exp_q.delete();
            return;
        end
        arrival = (arr_q.size() > 0) && (arr_q[0] == ecyc);
        if (arrival) void'(arr_q.pop_front());
        if (rx.BUS_EN && !prev_en) arr_q.push_back(ecyc + NS);
        prev_en = rx.BUS_EN;
        if (arrival && (!m_valid || rx.READY)) begin
            m_word = rx.UNSYNC_BUS;
            m_valid = 1'b1;
            e.word = rx.UNSYNC_BUS;
            e.cyc  = ecyc;
            exp_q.push_back(e);
        end else if (arrival) begin
            m_ovr = 1'b1;
            if (m_cnt < MAXC) m_cnt++;
        end else if (m_valid && rx.READY) begin
            m_valid = 1'b0;
        end
        if (rx.CLR_OVR) begin
            m_ovr = 1'b0;
            m_cnt = 0;
        end
    endtask

    task automatic monitor_edge();
        exp_t e;
        check("valid", rx.VALID, m_valid);
        check("overrun", rx.OVERRUN, m_ovr);
        check("drop_cnt", rx.DROP_CNT, m_cnt);
        check("sync_bus_hold", rx.SYNC_BUS, m_word);
        if (rx.ENABLE_PULSE) begin
            pulse_cnt++;
            last_pulse_cyc = ecyc;
            if (exp_q.size() == 0) begin
                check("sb_expected_entry", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("sb_word", rx.SYNC_BUS, e.word);
                check("sb_cycle", ecyc, e.cyc);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= ecyc) begin
            check("sb_pulse_present", rx.ENABLE_PULSE, 1);
            void'(exp_q.pop_front());
        end
    endtask

    // One BUS_EN pulse; optional special READY/CLR_OVR drive on the arrival edge.
    task automatic pulse(input logic [BW-1:0] word, input int hi, input int lo, input bit rnd,
                         input bit sp, input bit sp_ready, input bit sp_clr);
        logic saved = 1'b0;
        for (int i = 0; i < hi + lo; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                rx.UNSYNC_BUS = word;
                start_cyc = ecyc;
            end
            rx.BUS_EN = (i < hi);
            if (rnd) begin
                rx.READY   = 1'($urandom_range(0, 1));
                rx.CLR_OVR = ($urandom_range(0, 19) == 0);
            end
            if (sp && i == NS) begin
                saved      = rx.READY;
                rx.READY   = sp_ready;
                rx.CLR_OVR = sp_clr;
            end
            if (sp && i == NS + 1) begin
                rx.READY   = saved;
                rx.CLR_OVR = 1'b0;
            end
        end
    endtask

    initial begin
        int p0;
        int rel;
        rx.UNSYNC_BUS = '0;
        rx.BUS_EN     = 1'b0;
        rx.READY      = 1'b0;
        rx.CLR_OVR    = 1'b0;

        fork
            forever begin
                @(posedge CLK);
                ecyc++;
                model_edge();
                #1;
                monitor_edge();
            end
            begin
                #1000000;
                $display("FAIL watchdog: simulation time limit reached");
                n_fail++;
                summary();
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge CLK);
        check("rst_valid", rx.VALID, 0);
        check("rst_sync_bus", rx.SYNC_BUS, 0);
        check("rst_pulse", rx.ENABLE_PULSE, 0);
        check("rst_drop_cnt", rx.DROP_CNT, 0);
        RST = 1'b0;

        // 1: first capture and its latency
        p0 = pulse_cnt;
        pulse(8'hA5, NS + 2, NS + 2, 1'b0, 1'b0, 1'b0, 1'b0);
        check("p1_pulse_count", pulse_cnt - p0, 1);
        check("p1_pulse_cycle", last_pulse_cyc, start_cyc + 1 + NS);
        check("p1_sync_bus", rx.SYNC_BUS, 8'hA5);
        check("p1_valid", rx.VALID, 1);

        // 2: drop under back-pressure, then consume
        p0 = pulse_cnt;
        pulse(8'h3C, NS + 2, NS + 2, 1'b0, 1'b0, 1'b0, 1'b0);
        check("p2_pulse_count", pulse_cnt - p0, 0);
        check("p2_sync_bus", rx.SYNC_BUS, 8'hA5);
        check("p2_overrun", rx.OVERRUN, 1);
        check("p2_drop_cnt", rx.DROP_CNT, 1);
        @(negedge CLK) rx.READY = 1'b1;
        @(negedge CLK) rx.READY = 1'b0;
        check("p2_valid_after_ready", rx.VALID, 0);

        // 3: consume and arrive on the same edge
        @(negedge CLK) rx.CLR_OVR = 1'b1;
        @(negedge CLK) rx.CLR_OVR = 1'b0;
        p0 = pulse_cnt;
        pulse(8'h77, NS + 2, NS + 2, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(8'h5A, NS + 2, NS + 2, 1'b0, 1'b1, 1'b1, 1'b0);
        check("p3_pulse_count", pulse_cnt - p0, 2);
        check("p3_sync_bus", rx.SYNC_BUS, 8'h5A);
        check("p3_valid", rx.VALID, 1);
        check("p3_overrun", rx.OVERRUN, 0);

        // 4: saturation, then clear colliding with a drop
        for (int i = 0; i < 260; i++) begin
            pulse(8'($urandom) | 8'h01, NS + 1, NS + 1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("p4_drop_cnt_sat", rx.DROP_CNT, 8'hFF);
        check("p4_sync_bus", rx.SYNC_BUS, 8'h5A);
        pulse(8'h11, NS + 1, NS + 1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("p4_clr_overrun", rx.OVERRUN, 0);
        check("p4_clr_drop_cnt", rx.DROP_CNT, 0);
        pulse(8'h22, NS + 1, NS + 1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("p4_redrop_cnt", rx.DROP_CNT, 1);

        // 5: reset with a partially filled chain
        @(negedge CLK);
        rx.UNSYNC_BUS = 8'hC3;
        rx.BUS_EN     = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("p5_rst_valid", rx.VALID, 0);
        check("p5_rst_sync_bus", rx.SYNC_BUS, 0);
        check("p5_rst_pulse", rx.ENABLE_PULSE, 0);
        check("p5_rst_overrun", rx.OVERRUN, 0);
        check("p5_rst_drop_cnt", rx.DROP_CNT, 0);
        p0 = pulse_cnt;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        rel = ecyc;
        repeat (NS + 4) @(negedge CLK);
        rx.BUS_EN = 1'b0;
        repeat (NS + 2) @(negedge CLK);
        check("p5_pulse_count", pulse_cnt - p0, 1);
        check("p5_pulse_cycle", last_pulse_cyc, rel + NS + 1);
        check("p5_sync_bus", rx.SYNC_BUS, 8'hC3);

        // 6: long high phase, falling edge ignored
        rx.READY = 1'b1;
        p0 = pulse_cnt;
        pulse(8'h96, 50, 50, 1'b0, 1'b0, 1'b0, 1'b0);
        check("p6_pulse_count", pulse_cnt - p0, 1);

        // 7: randomized traffic
        for (int i = 0; i < 200; i++) begin
            pulse(8'($urandom), $urandom_range(NS + 1, NS + 5), $urandom_range(NS + 1, NS + 5),
                  1'b1, 1'b0, 1'b0, 1'b0);
        end
        rx.READY   = 1'b0;
        rx.CLR_OVR = 1'b0;
        repeat (NS + 4) @(negedge CLK);
        check("sb_drain", exp_q.size(), 0);

        summary();
        $finish;
    end
endmodule
